// File: rtl/ultrasonido_pkg.sv
// Shared FSM encoding and default 50 MHz timing for the ultrasonic ranger sequencer.
package ultrasonido_pkg;

  localparam int unsigned CLK_HZ             = 32'd50_000_000;
  localparam int unsigned DEF_TRIG_CYCLES    = CLK_HZ / 32'd100_000;             // 10 us
  localparam int unsigned DEF_TIMEOUT_CYCLES = (CLK_HZ / 32'd1_000) * 32'd30;    // 30 ms
  localparam int unsigned DEF_PERIOD_CYCLES  = (CLK_HZ / 32'd1_000) * 32'd60;    // 60 ms
  localparam int unsigned DEF_CYC_PER_CM     = (CLK_HZ / 32'd1_000_000) * 32'd58; // 58 us/cm

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

endpackage

// File: rtl/ultrasonido_ctrl_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous sensor inputs; resets to 0.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {W{1'b0}};
      q      <= {W{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/ultrasonido_ctrl.sv
// HC-SR04-class ranger sequencer: trigger, echo-width measurement, cm conversion,
// echo timeouts and re-trigger holdoff, one result per valid strobe.
module ultrasonido_ctrl
  import ultrasonido_pkg::*;
#(
  parameter int unsigned CNT_W          = 20,
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
  parameter int unsigned CYC_PER_CM     = DEF_CYC_PER_CM,
  parameter int unsigned CM_W           = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             echo,
  output logic             trig,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] echo_cycles,
  output logic [CM_W-1:0]  distance_cm
);

  localparam int unsigned     PW           = CNT_W + 2;
  localparam logic [PW-1:0]   ZERO_P       = {PW{1'b0}};
  localparam logic [PW-1:0]   ONE_P        = PW'(32'd1);
  localparam logic [PW-1:0]   TRIG_LAST    = PW'(TRIG_CYCLES - 32'd1);
  localparam logic [PW-1:0]   TIMEOUT_MAX  = PW'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0]   TIMEOUT_LAST = PW'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [PW-1:0]   PERIOD_LAST  = PW'(PERIOD_CYCLES - 32'd1);
  localparam logic [PW-1:0]   PRE_LAST     = PW'(CYC_PER_CM - 32'd1);
  localparam logic [PW-1:0]   OUT_MAX      = {2'b00, {CNT_W{1'b1}}};
  localparam logic [CM_W-1:0] CM_MAX       = {CM_W{1'b1}};
  localparam logic [CM_W-1:0] CM_ONE       = CM_W'(32'd1);

  // Internal counts run CNT_W+2 bits wide; the published width saturates rather than wraps.
  function automatic logic [CNT_W-1:0] clamp_out(input logic [PW-1:0] v);
    logic [CNT_W-1:0] r;
    if (v > OUT_MAX) begin
      r = {CNT_W{1'b1}};
    end else begin
      r = v[CNT_W-1:0];
    end
    return r;
  endfunction

  logic            echo_s;
  logic            echo_d_r;
  logic            rise_s;
  logic            fall_s;
  state_e          state_r;
  state_e          state_nxt_s;
  logic            tick_s;
  logic            post_ok_s;
  logic            post_to_s;
  logic [PW-1:0]   phase_cnt_r;
  logic [PW-1:0]   per_r;
  logic [PW-1:0]   cyc_cnt_r;
  logic [PW-1:0]   pre_r;
  logic [CM_W-1:0] cm_r;

  sync_2ff #(.W(1)) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  assign rise_s = echo_s & ~echo_d_r;
  assign fall_s = ~echo_s & echo_d_r;

  // Previous synchronised echo for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_d_r <= 1'b0;
    end else begin
      echo_d_r <= echo_s;
    end
  end

  // Next state, result-posting events and the per-high-cycle count enable.
  always_comb begin
    state_nxt_s = state_r;
    tick_s      = 1'b0;
    post_ok_s   = 1'b0;
    post_to_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start || continuous) begin
          state_nxt_s = ST_TRIG;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TRIG: begin
        if (phase_cnt_r == TRIG_LAST) begin
          state_nxt_s = ST_WAIT_RISE;
        end else begin
          state_nxt_s = ST_TRIG;
        end
      end
      ST_WAIT_RISE: begin
        // The rise cycle is itself an echo-high cycle, so it is counted here.
        if (rise_s) begin
          state_nxt_s = ST_MEASURE;
          tick_s      = 1'b1;
        end else if (phase_cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = ST_HOLDOFF;
          post_to_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_RISE;
        end
      end
      ST_MEASURE: begin
        if (fall_s) begin
          state_nxt_s = ST_HOLDOFF;
          post_ok_s   = 1'b1;
        end else if (cyc_cnt_r == TIMEOUT_MAX) begin
          state_nxt_s = ST_HOLDOFF;
          post_to_s   = 1'b1;
        end else begin
          state_nxt_s = ST_MEASURE;
          tick_s      = echo_s;
        end
      end
      ST_HOLDOFF: begin
        // A stuck-high echo must clear before the sensor is triggered again.
        if ((per_r == PERIOD_LAST) && !echo_s) begin
          if (continuous) begin
            state_nxt_s = ST_TRIG;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_HOLDOFF;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Trigger-width / wait-for-rise timer, restarted on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt_r <= ZERO_P;
    end else if (state_nxt_s != state_r) begin
      phase_cnt_r <= ZERO_P;
    end else if ((state_r == ST_TRIG || state_r == ST_WAIT_RISE) && (phase_cnt_r != {PW{1'b1}})) begin
      phase_cnt_r <= phase_cnt_r + ONE_P;
    end else begin
      phase_cnt_r <= phase_cnt_r;
    end
  end

  // Trigger-to-trigger period counter, zeroed on every entry into TRIG.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_r <= ZERO_P;
    end else if ((state_r == ST_IDLE) || ((state_nxt_s == ST_TRIG) && (state_r != ST_TRIG))) begin
      per_r <= ZERO_P;
    end else if (per_r != PERIOD_LAST) begin
      per_r <= per_r + ONE_P;
    end else begin
      per_r <= per_r;
    end
  end

  // Echo width, cm prescaler and saturating cm count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_r <= ZERO_P;
      pre_r     <= ZERO_P;
      cm_r      <= {CM_W{1'b0}};
    end else if (state_r == ST_IDLE || state_r == ST_TRIG) begin
      cyc_cnt_r <= ZERO_P;
      pre_r     <= ZERO_P;
      cm_r      <= {CM_W{1'b0}};
    end else if (tick_s) begin
      if (cyc_cnt_r != TIMEOUT_MAX) begin
        cyc_cnt_r <= cyc_cnt_r + ONE_P;
      end else begin
        cyc_cnt_r <= cyc_cnt_r;
      end
      if (pre_r == PRE_LAST) begin
        pre_r <= ZERO_P;
        if (cm_r != CM_MAX) begin
          cm_r <= cm_r + CM_ONE;
        end else begin
          cm_r <= cm_r;
        end
      end else begin
        pre_r <= pre_r + ONE_P;
      end
    end else begin
      cyc_cnt_r <= cyc_cnt_r;
      pre_r     <= pre_r;
      cm_r      <= cm_r;
    end
  end

  // Registered outputs; results are held until the next valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig        <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      echo_cycles <= {CNT_W{1'b0}};
      distance_cm <= {CM_W{1'b0}};
    end else begin
      trig  <= (state_nxt_s == ST_TRIG);
      busy  <= (state_nxt_s != ST_IDLE);
      valid <= post_ok_s | post_to_s;
      if (post_ok_s) begin
        echo_cycles <= clamp_out(cyc_cnt_r);
        distance_cm <= cm_r;
        timeout     <= 1'b0;
      end else if (post_to_s) begin
        if (state_r == ST_WAIT_RISE) begin
          echo_cycles <= clamp_out(TIMEOUT_MAX);
        end else begin
          echo_cycles <= clamp_out(cyc_cnt_r);
        end
        distance_cm <= CM_MAX;
        timeout     <= 1'b1;
      end else begin
        echo_cycles <= echo_cycles;
        distance_cm <= distance_cm;
        timeout     <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Directed bench for ultrasonido_ctrl, run with shortened timing parameters so
// every scenario (timeouts, holdoff, continuous mode) fits in a short simulation.
module tb_ultrasonido_ctrl;

  localparam int CNT_W  = 12;
  localparam int CM_W   = 4;
  localparam int TRIG_C = 10;
  localparam int TO_C   = 600;
  localparam int PER_C  = 1200;
  localparam int CPC    = 29;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             continuous = 1'b0;
  logic             echo = 1'b0;
  logic             trig;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] echo_cycles;
  logic [CM_W-1:0]  distance_cm;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int valid_cnt = 0;

  ultrasonido_ctrl #(
    .CNT_W          (CNT_W),
    .TRIG_CYCLES    (TRIG_C),
    .TIMEOUT_CYCLES (TO_C),
    .PERIOD_CYCLES  (PER_C),
    .CYC_PER_CM     (CPC),
    .CM_W           (CM_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .echo        (echo),
    .trig        (trig),
    .busy        (busy),
    .valid       (valid),
    .timeout     (timeout),
    .echo_cycles (echo_cycles),
    .distance_cm (distance_cm)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) if (valid === 1'b1) valid_cnt <= valid_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic sig_of(input int sel);
    logic r;
    case (sel)
      0:       r = trig;
      1:       r = valid;
      default: r = busy;
    endcase
    return r;
  endfunction

  // n = negedges waited until the signal equals val, or -1 if the limit expired.
  task automatic wait_sig(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (sig_of(sel) !== val) begin
      if (n >= limit) begin
        n = -1;
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    repeat (3) @(negedge clk);
    obs = {trig, busy, valid, timeout, echo_cycles, distance_cm};
    vectors++;
    if (obs !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, expected 0", obs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || trig !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b trig=%b, expected 0 0", busy, trig);
    end
  endtask

  task automatic test_single_shot(input string name, input int width, input int exp_cyc, input int exp_cm);
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(0, 1'b1, 20, n);
    vectors++;
    if (n < 0) begin
      miscompares++;
      $display("FAIL %s trig_rise: trig never rose", name);
    end
    wait_sig(0, 1'b0, 4 * TRIG_C, n);
    vectors++;
    if (n !== TRIG_C) begin
      miscompares++;
      $display("FAIL %s trig_width: got %0d cycles, expected %0d", name, n, TRIG_C);
    end
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (width) @(negedge clk);
    echo = 1'b0;
    wait_sig(1, 1'b1, 20, n);
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL %s valid_latency: got %0d, expected 3", name, n);
    end
    vectors++;
    if (echo_cycles !== exp_cyc[CNT_W-1:0]) begin
      miscompares++;
      $display("FAIL %s echo_cycles: got %0d, expected %0d", name, echo_cycles, exp_cyc);
    end
    vectors++;
    if (distance_cm !== exp_cm[CM_W-1:0] || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL %s distance: got %0d timeout=%b, expected %0d timeout=0", name, distance_cm, timeout, exp_cm);
    end
    @(negedge clk);
    vectors++;
    if (valid !== 1'b0 || echo_cycles !== exp_cyc[CNT_W-1:0]) begin
      miscompares++;
      $display("FAIL %s hold: valid=%b echo_cycles=%0d, expected 0 and %0d", name, valid, echo_cycles, exp_cyc);
    end
    wait_sig(2, 1'b0, 3 * PER_C, n);
    vectors++;
    if (n < 0) begin
      miscompares++;
      $display("FAIL %s idle_return: busy stayed high", name);
    end
  endtask

  task automatic test_no_echo();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(0, 1'b0, 4 * TRIG_C, n);
    wait_sig(1, 1'b1, TO_C + 50, n);
    vectors++;
    if (n !== TO_C) begin
      miscompares++;
      $display("FAIL no_echo latency: got %0d, expected %0d", n, TO_C);
    end
    vectors++;
    if (timeout !== 1'b1 || distance_cm !== 4'd15 || echo_cycles !== 12'd600) begin
      miscompares++;
      $display("FAIL no_echo result: timeout=%b cm=%0d cyc=%0d, expected 1 15 600", timeout, distance_cm, echo_cycles);
    end
    wait_sig(2, 1'b0, 3 * PER_C, n);
    vectors++;
    if (n < 0) begin
      miscompares++;
      $display("FAIL no_echo idle_return: busy stayed high");
    end
  endtask

  task automatic test_continuous();
    int n;
    int t[3];
    int v0;
    int hits;
    v0 = valid_cnt;
    continuous = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_sig(0, 1'b1, 2 * PER_C, n);
      vectors++;
      if (n < 0) begin
        miscompares++;
        $display("FAIL cont_trig%0d: trig never rose", k);
      end
      t[k] = cycle;
      wait_sig(0, 1'b0, 4 * TRIG_C, n);
      repeat (5) @(negedge clk);
      echo = 1'b1;
      if (k == 1) start = 1'b1;
      repeat (50) @(negedge clk);
      start = 1'b0;
      echo = 1'b0;
      if (k == 2) continuous = 1'b0;
      wait_sig(1, 1'b1, 20, n);
      vectors++;
      if (n !== 3 || echo_cycles !== 12'd50 || distance_cm !== 4'd1 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL cont_result%0d: lat=%0d cyc=%0d cm=%0d to=%b, expected 3 50 1 0", k, n, echo_cycles, distance_cm, timeout);
      end
    end
    wait_sig(2, 1'b0, 2 * PER_C, n);
    vectors++;
    if (n < 0) begin
      miscompares++;
      $display("FAIL cont_stop: busy stayed high after continuous dropped");
    end
    vectors++;
    if (t[1] - t[0] !== PER_C || t[2] - t[1] !== PER_C) begin
      miscompares++;
      $display("FAIL cont_period: spacing %0d %0d, expected %0d", t[1] - t[0], t[2] - t[1], PER_C);
    end
    vectors++;
    if (valid_cnt - v0 !== 3) begin
      miscompares++;
      $display("FAIL cont_valid_count: got %0d, expected 3", valid_cnt - v0);
    end
    hits = 0;
    for (int i = 0; i < PER_C + 100; i++) begin
      @(negedge clk);
      if (trig !== 1'b0 || busy !== 1'b0) hits++;
    end
    vectors++;
    if (hits !== 0) begin
      miscompares++;
      $display("FAIL cont_no_queue: %0d busy/trig cycles after stop, expected 0", hits);
    end
  endtask

  task automatic test_stuck_echo();
    int n;
    int trig_hits;
    int busy_low;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(0, 1'b0, 4 * TRIG_C, n);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    wait_sig(1, 1'b1, TO_C + 20, n);
    vectors++;
    if (n !== TO_C + 3) begin
      miscompares++;
      $display("FAIL stuck latency: got %0d, expected %0d", n, TO_C + 3);
    end
    vectors++;
    if (timeout !== 1'b1 || distance_cm !== 4'd15 || echo_cycles !== 12'd600) begin
      miscompares++;
      $display("FAIL stuck result: timeout=%b cm=%0d cyc=%0d, expected 1 15 600", timeout, distance_cm, echo_cycles);
    end
    trig_hits = 0;
    busy_low = 0;
    for (int i = n; i < 1500; i++) begin
      @(negedge clk);
      if (trig !== 1'b0) trig_hits++;
      if (busy !== 1'b1) busy_low++;
    end
    vectors++;
    if (trig_hits !== 0 || busy_low !== 0) begin
      miscompares++;
      $display("FAIL stuck holdoff: trig_hits=%0d busy_low=%0d, expected 0 0", trig_hits, busy_low);
    end
    echo = 1'b0;
    wait_sig(2, 1'b0, 20, n);
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL stuck release: busy dropped after %0d, expected 3", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    logic [19:0] obs;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(0, 1'b1, 20, n);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (trig !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_trig: trig=%b busy=%b, expected 0 0", trig, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sig(0, 1'b0, 4 * TRIG_C, n);
    repeat (5) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {trig, busy, valid, timeout, echo_cycles, distance_cm};
    vectors++;
    if (obs !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_measure: got %h, expected 0", obs);
    end
    repeat (2) @(negedge clk);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL reset_release: %0d cycles with valid/busy, expected 0", bad);
    end
    test_single_shot("after_reset", 300, 300, 10);
  endtask

  initial begin
    test_reset();
    test_single_shot("shot_300", 300, 300, 10);
    test_single_shot("shot_290", 290, 290, 10);
    test_single_shot("shot_28", 28, 28, 0);
    test_single_shot("shot_29", 29, 29, 1);
    test_single_shot("shot_cm_sat", 500, 500, 15);
    test_single_shot("shot_at_timeout", 600, 600, 15);
    test_no_echo();
    test_continuous();
    test_stuck_echo();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
